seq_addsub_n: RTL and testbench
===============================

# seq_addsub_n

Parametrised multi-cycle adder/subtractor: the next generation of the team's 2-bit gate-level adder. It is generalised to WIDTH bits and adds subtract mode, signed overflow and a start/busy/done handshake. The operation is computed CHUNK bits per clock through a small ripple-carry chunk adder, so area scales with CHUNK rather than WIDTH. It sits between the lab's operand registers/switch inputs and the result display logic.

## Interface
- WIDTH, default 8: operand and result width in bits; ≥ 2.
- CHUNK, default 2: bits processed per clock.
  - 1 ≤ CHUNK ≤ WIDTH.
  - WIDTH % CHUNK == 0.
  - Other combinations are illegal; flag them in elaboration.
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a−b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. In subtract mode, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch a → opA.
  - Latch (sub ? ~b : b) → opB.
  - carry ← sub; cnt ← 0; go to RUN.
  - start=0: stay in IDLE.
- RUN, each cycle:
  - Chunk adder computes opA[CHUNK-1:0] + opB[CHUNK-1:0] + carry.
  - CHUNK result bits shift into sum from the MSB end (logical shift right of the sum register).
  - opA and opB shift right by CHUNK.
  - carry ← chunk carry-out; cnt++.
  - On the last chunk (cnt == WIDTH/CHUNK−1), also capture:
    - cout ← chunk carry-out;
    - ovf ← carry into the MSB XOR carry out of the MSB.
  - Then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Output holding:
  - sum, cout and ovf hold their values from DONE until the next start is accepted.
  - sum is not valid while busy=1, because partial shifts are visible.
- Ignored start:
  - start in RUN or DONE is ignored, not queued.
  - Operand or sub changes after acceptance have no effect.
- Reset (rst_n=0 at a clock edge, including mid-RUN):
  - state=IDLE, cnt=0, opA/opB/carry cleared.
  - Outputs: busy=0, done=0, sum=0, cout=0, ovf=0.
  - The aborted operation produces no done.
- Arithmetic:
  - sum = (a ± b) mod 2^WIDTH.
  - ovf is defined over signed interpretation of a and b.
  - cnt width is clog2(WIDTH/CHUNK), minimum 1 bit.

## Timing
- start accepted at edge 0 → busy high from edge 0 through edge WIDTH/CHUNK−1.
- done high in the cycle after edge WIDTH/CHUNK. Latency is WIDTH/CHUNK + 1 cycles from start to done.
- Throughput: one operation per WIDTH/CHUNK + 2 cycles. The earliest next start is the cycle after done.
- All outputs are registered. The only combinational path is the CHUNK-bit ripple chain inside one cycle.
- CHUNK == WIDTH: one RUN cycle, done at edge 2.

## Structure
- Shared package (lab_pkg): state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2, and a shared clog2 function.
- Sub-module chunk_adder #(CHUNK): combinational ripple of gate-level full adders.
  - Ports: x, y, cin, s, cout, and c_msb_in (carry into bit CHUNK−1, used for ovf).
  - The full-adder cell uses the xor/and/or form already used by the team's adders.
- Top level contains the FSM, counter and shift registers only.

## Test plan
- WIDTH=8, CHUNK=2, add 0x5A+0x3C: sum=0x96, cout=0, ovf=1. done is exactly 5 cycles after start; busy is high 4 cycles.
- Sub 0x10−0x20: sum=0xF0, cout=0 (borrow), ovf=0. Sub 0x80−0x01: sum=0x7F, cout=1, ovf=1.
- Add 0xFF+0x01: sum=0x00, cout=1, ovf=0.
  - Then pulse start again with 0x01+0x01 during RUN: ignored, sum stays 0x00 path.
  - The next accepted start gives 0x02.
- Drop rst_n for one cycle during RUN:
  - All outputs are 0 on the next cycle; no done pulse.
  - A new start afterwards completes normally.
- WIDTH=8, CHUNK=8 and WIDTH=8, CHUNK=1:
  - Random 1000-op sweep against a behavioural reference for sum/cout/ovf.
  - Latency 2 and 9 cycles respectively.

Source files
------------

// File: rtl/lab_pkg.sv
// Shared definitions for the lab arithmetic blocks: FSM state encodings and a
// constant-evaluable ceiling-log2 helper.
package lab_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bounded loop keeps this usable in constant expressions and synthesis.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry adder built from xor/and/or full-adder cells; also
// exposes the carry into its top bit so the caller can form signed overflow.
module chunk_adder #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0]   w_c;
  logic [CHUNK-1:0] w_p;

  assign w_c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign w_p[i]   = x[i] ^ y[i];
    assign s[i]     = w_p[i] ^ w_c[i];
    assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & w_p[i]);
  end

  assign cout     = w_c[CHUNK];
  assign c_msb_in = w_c[CHUNK-1];

endmodule

// File: rtl/seq_addsub_n.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock,
// start/busy/done handshake, registered sum/cout/ovf.
module seq_addsub_n
  import lab_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_addsub_n: illegal WIDTH=%0d / CHUNK=%0d", WIDTH, CHUNK);
  end

  localparam int unsigned NumChunks = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned CntW      = (clog2(NumChunks) < 1) ? 1 : clog2(NumChunks);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumChunks - 1);

  state_e           r_state, w_state_next;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_op_a, r_op_b, r_sum;
  logic             r_carry, r_cout, r_ovf;

  logic [CHUNK-1:0] w_s;
  logic             w_co, w_c_msb;
  logic             w_last;

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .x        (r_op_a[CHUNK-1:0]),
    .y        (r_op_b[CHUNK-1:0]),
    .cin      (r_carry),
    .s        (w_s),
    .cout     (w_co),
    .c_msb_in (w_c_msb)
  );

  assign w_last = (r_cnt == LastCnt);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy = (r_state == StRun);
    done = (r_state == StDone);
  end

  // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_op_a  <= a;
            r_op_b  <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
          end
        end
        StRun: begin
          r_sum   <= (r_sum >> CHUNK) | (WIDTH'(w_s) << (WIDTH - CHUNK));
          r_op_a  <= r_op_a >> CHUNK;
          r_op_b  <= r_op_b >> CHUNK;
          r_carry <= w_co;
          r_cnt   <= r_cnt + CntW'(1);
          if (w_last) begin
            r_cout <= w_co;
            r_ovf  <= w_c_msb ^ w_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_seq_addsub_n.sv
// Scoreboard bench: directed and random ops on WIDTH=8/CHUNK=2, plus random
// sweeps on CHUNK=8 and CHUNK=1 instances, checked against an arithmetic model.
module tb_seq_addsub_n;

  localparam int unsigned W  = 8;
  localparam int unsigned NC = W / 2;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int unsigned  t0;
  } exp_t;

  logic        clk = 1'b0;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          sw_done [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                 input logic xs, input int unsigned t0);
    exp_t m;
    int   sa, sb, r, ua, ub;
    sa = int'($signed(xa));
    sb = int'($signed(xb));
    ua = int'(xa);
    ub = int'(xb);
    r  = xs ? sa - sb : sa + sb;
    m.sum  = xs ? W'(ua - ub) : W'(ua + ub);
    m.cout = xs ? (ua >= ub) : (ua + ub > 255);
    m.ovf  = (r > 127) || (r < -128);
    m.t0   = t0;
    return m;
  endfunction

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- main instance: WIDTH=8, CHUNK=2 ----------------
  logic         rst_n, start, sub, busy, done, cout, ovf;
  logic [W-1:0] a, b, sum;
  exp_t         q_main[$];
  exp_t         e_m;

  seq_addsub_n #(
    .WIDTH (W),
    .CHUNK (2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always @(negedge clk) begin
    if (done) begin
      if (q_main.size() == 0) begin
        check("main unexpected done", 1, 0);
      end else begin
        e_m = q_main.pop_front();
        check("main sum", sum, e_m.sum);
        check("main cout", cout, e_m.cout);
        check("main ovf", ovf, e_m.ovf);
        check("main latency", cyc - e_m.t0, NC + 1);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                       input bit inject);
    int busy_n;
    bit seen;
    busy_n = 0;
    seen   = 1'b0;
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    q_main.push_back(model(ta, tb_v, ts, cyc));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'(($urandom));
    for (int i = 0; i < 20; i++) begin
      busy_n += int'(busy);
      if (done) begin
        seen = 1'b1;
        break;
      end
      // A second request while running must be dropped.
      start = inject && (i == 1);
      if (start) begin
        a = 8'h01; b = 8'h01; sub = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("main done seen", 32'(seen), 1);
    check("main busy cycles", busy_n, NC);
  endtask

  initial begin
    exp_t h;
    int   dn;
    bit   all_done;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    check("reset ovf", ovf, 0);
    rst_n = 1'b1;

    do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    h = model(8'h5A, 8'h3C, 1'b0, 0);
    repeat (2) @(negedge clk);
    check("hold sum", sum, h.sum);
    check("hold cout", cout, h.cout);
    check("hold ovf", ovf, h.ovf);

    do_op(8'h10, 8'h20, 1'b1, 1'b0);
    do_op(8'h80, 8'h01, 1'b1, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b1);
    do_op(8'h01, 8'h01, 1'b0, 1'b0);

    // Abort an operation with a one-cycle reset in the middle of RUN.
    @(negedge clk);
    a = 8'h77; b = 8'h11; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort sum", sum, 0);
    check("abort cout", cout, 0);
    check("abort ovf", ovf, 0);
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      dn += int'(done);
    end
    check("abort no done", dn, 0);
    do_op(8'h33, 8'h44, 1'b1, 1'b0);

    for (int k = 0; k < 200; k++) begin
      do_op(W'($urandom), W'($urandom), 1'(($urandom)), 1'(($urandom_range(0, 3) == 0)));
    end

    all_done = 1'b0;
    for (int t = 0; t < 60000 && !all_done; t++) begin
      @(negedge clk);
      all_done = sw_done[0] && sw_done[1];
    end
    check("sweeps finished", 32'(all_done), 1);
    repeat (4) @(negedge clk);
    check("main queue drained", q_main.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- sweep instances: CHUNK=8 and CHUNK=1 ----------------
  for (genvar g = 0; g < 2; g++) begin : g_sw
    localparam int unsigned Ch  = (g == 0) ? 8 : 1;
    localparam int unsigned Nc  = W / Ch;

    logic         s_rst_n, s_start, s_sub, s_busy, s_done, s_cout, s_ovf;
    logic [W-1:0] s_a, s_b, s_sum;
    exp_t         q[$];
    exp_t         e;

    seq_addsub_n #(
      .WIDTH (W),
      .CHUNK (Ch)
    ) u_dut_sw (
      .clk   (clk),
      .rst_n (s_rst_n),
      .start (s_start),
      .sub   (s_sub),
      .a     (s_a),
      .b     (s_b),
      .busy  (s_busy),
      .done  (s_done),
      .sum   (s_sum),
      .cout  (s_cout),
      .ovf   (s_ovf)
    );

    always @(negedge clk) begin
      if (s_done) begin
        if (q.size() == 0) begin
          check($sformatf("sweep%0d unexpected done", Ch), 1, 0);
        end else begin
          e = q.pop_front();
          check($sformatf("sweep%0d sum", Ch), s_sum, e.sum);
          check($sformatf("sweep%0d cout", Ch), s_cout, e.cout);
          check($sformatf("sweep%0d ovf", Ch), s_ovf, e.ovf);
          check($sformatf("sweep%0d latency", Ch), cyc - e.t0, Nc + 1);
        end
      end
    end

    initial begin
      logic [W-1:0] ra, rb;
      logic         rs;
      bit           seen;
      s_rst_n = 1'b0; s_start = 1'b0; s_sub = 1'b0; s_a = '0; s_b = '0;
      repeat (2) @(negedge clk);
      s_rst_n = 1'b1;
      for (int k = 0; k < 1000; k++) begin
        ra = W'($urandom); rb = W'($urandom); rs = 1'(($urandom));
        @(negedge clk);
        s_a = ra; s_b = rb; s_sub = rs; s_start = 1'b1;
        q.push_back(model(ra, rb, rs, cyc));
        seen = 1'b0;
        for (int i = 0; i < int'(Nc) + 6; i++) begin
          @(negedge clk);
          if (s_done) begin
            seen = 1'b1;
            break;
          end
          // Noise on the request lines while the operation is in flight.
          s_start = 1'(($urandom));
          s_a = W'($urandom); s_b = W'($urandom); s_sub = 1'(($urandom));
        end
        s_start = 1'b0;
        if (!seen) check($sformatf("sweep%0d done seen", Ch), 0, 1);
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      repeat (2) @(negedge clk);
      check($sformatf("sweep%0d queue drained", Ch), q.size(), 0);
      sw_done[g] = 1'b1;
    end
  end

endmodule
